audio_adc_receiver: RTL



---
 rtl/audio_rx_pkg.sv | 20 ++
 rtl/audio_adc_receiver_sync_edge.sv | 37 +++
 rtl/audio_adc_receiver.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/audio_rx_pkg.sv
// Shared definitions for the codec ADC receive path: default sample width,
// receiver state encoding and bit-counter sizing.
`timescale 1ns/1ps
package audio_rx_pkg;

   localparam int SAMPLE_W_DEF = 16;

   typedef enum logic [1:0] {
      ST_ALIGN = 2'd0,
      ST_SKIP  = 2'd1,
      ST_SHIFT = 2'd2,
      ST_HOLD  = 2'd3
   } rx_state_e;

   // Counter must be able to hold the value w itself.
   function automatic int cnt_width(input int w);
      return $clog2(w + 1);
   endfunction

endpackage

// File: rtl/audio_adc_receiver_sync_edge.sv
// sync_edge: 2-FF synchronizer with rising-edge detect for the strobe input, plus an
// equal-depth plain synchronizer for companion data bits so both stay aligned.
`timescale 1ns/1ps
module sync_edge #(
   parameter int W = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         edge_in,
   input  logic [W-1:0] data_in,
   output logic         rise,
   output logic [W-1:0] data_q
);
   logic         edge_meta_r, edge_sync_r, edge_prev_r;
   logic [W-1:0] data_meta_r, data_sync_r;

   // Two-stage capture of all codec pins, one extra stage for edge history.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         edge_meta_r <= 1'b0;
         edge_sync_r <= 1'b0;
         edge_prev_r <= 1'b0;
         data_meta_r <= {W{1'b0}};
         data_sync_r <= {W{1'b0}};
      end else begin
         edge_meta_r <= edge_in;
         edge_sync_r <= edge_meta_r;
         edge_prev_r <= edge_sync_r;
         data_meta_r <= data_in;
         data_sync_r <= data_meta_r;
      end
   end

   assign rise   = edge_sync_r & ~edge_prev_r;
   assign data_q = data_sync_r;

endmodule

// File: rtl/audio_adc_receiver.sv
// audio_adc_receiver: deserializes the codec ADC stream into L/R sample pairs in the iCLK domain.
// Optional peak meter is built when ADC_PEAK_METER_EN is defined.
`timescale 1ns/1ps
module audio_adc_receiver
   import audio_rx_pkg::*;
#(
   parameter int SAMPLE_W   = SAMPLE_W_DEF,
   parameter int DATA_DELAY = 1,
   parameter int LEFT_LEVEL = 1
) (
   input  logic                iCLK,
   input  logic                iRST_N,
   input  logic                iAUD_BCK,
   input  logic                iAUD_LRCK,
   input  logic                iAUD_ADCDAT,
`ifdef ADC_PEAK_METER_EN
   input  logic                iPEAK_CLR,
   output logic [SAMPLE_W-2:0] oPEAK_L,
   output logic [SAMPLE_W-2:0] oPEAK_R,
`endif
   output logic [SAMPLE_W-1:0] oAUD_inL,
   output logic [SAMPLE_W-1:0] oAUD_inR,
   output logic                oVALID,
   output logic                oFRAME_ERR
);
   localparam int               CNT_W    = cnt_width(SAMPLE_W);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SAMPLE_W - 1);
   localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);
   localparam logic             DELAYED  = 1'(DATA_DELAY != 0);
   localparam logic             LEFT_LVL = 1'(LEFT_LEVEL != 0);
   localparam rx_state_e        START_ST = (DATA_DELAY != 0) ? ST_SKIP : ST_SHIFT;

   logic [1:0]          sync_data_s;
   logic                bck_rise_s, lrck_s, dat_s;
   rx_state_e           state_r, state_nx_s;
   logic                primed_r, lr_last_r, slot_lr_r, left_held_r;
   logic                commit_r, valid_r, err_r;
   logic [CNT_W-1:0]    cnt_r;
   logic [SAMPLE_W-1:0] shift_r, left_hold_r, out_l_r, out_r_r, word_s;
   logic                lr_edge_s, first_s, shift_s, last_s, err_s, is_left_s;

   sync_edge #(.W(2)) u_sync (
      .clk     (iCLK),
      .rst_n   (iRST_N),
      .edge_in (iAUD_BCK),
      .data_in ({iAUD_ADCDAT, iAUD_LRCK}),
      .rise    (bck_rise_s),
      .data_q  (sync_data_s)
   );

   assign lrck_s    = sync_data_s[0];
   assign dat_s     = sync_data_s[1];
   // The first bit clock after reset only primes the LRCK history, so a slot is never entered mid-way.
   assign lr_edge_s = bck_rise_s & primed_r & (lrck_s != lr_last_r);
   assign word_s    = {shift_r[SAMPLE_W-2:0], dat_s};
   assign is_left_s = (slot_lr_r == LEFT_LVL);

   // LRCK level seen at the previous bit clock.
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         primed_r  <= 1'b0;
         lr_last_r <= 1'b0;
      end else if (bck_rise_s) begin
         primed_r  <= 1'b1;
         lr_last_r <= lrck_s;
      end
   end

   // Receiver state register.
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) state_r <= ST_ALIGN;
      else         state_r <= state_nx_s;
   end

   // Next-state logic; every move happens on a bit clock.
   always_comb begin
      state_nx_s = state_r;
      if (lr_edge_s) begin
         state_nx_s = START_ST;
      end else if (bck_rise_s) begin
         case (state_r)
            ST_SKIP:           state_nx_s = ST_SHIFT;
            ST_SHIFT:          state_nx_s = (cnt_r == LAST_CNT) ? ST_HOLD : ST_SHIFT;
            ST_ALIGN, ST_HOLD: state_nx_s = state_r;
            default:           state_nx_s = ST_ALIGN;
         endcase
      end else begin
         state_nx_s = state_r;
      end
   end

   // Datapath controls decoded from state and the current bit clock.
   always_comb begin
      first_s = 1'b0;
      shift_s = 1'b0;
      last_s  = 1'b0;
      err_s   = 1'b0;
      if (lr_edge_s) begin
         first_s = ~DELAYED;
         err_s   = (state_r == ST_SHIFT);
      end else if (bck_rise_s) begin
         case (state_r)
            ST_SKIP:  first_s = 1'b1;
            ST_SHIFT: begin
               shift_s = 1'b1;
               last_s  = (cnt_r == LAST_CNT);
            end
            default:  shift_s = 1'b0;
         endcase
      end else begin
         first_s = 1'b0;
      end
   end

   // Shift register, bit counter and channel tag of the current slot.
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         shift_r   <= {SAMPLE_W{1'b0}};
         cnt_r     <= {CNT_W{1'b0}};
         slot_lr_r <= 1'b0;
      end else begin
         if (first_s) begin
            shift_r <= {{(SAMPLE_W-1){1'b0}}, dat_s};
            cnt_r   <= ONE_CNT;
         end else if (lr_edge_s) begin
            shift_r <= {SAMPLE_W{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
         end else if (shift_s) begin
            shift_r <= word_s;
            cnt_r   <= cnt_r + ONE_CNT;
         end
         if (lr_edge_s) slot_lr_r <= lrck_s;
      end
   end

   // Left word is parked until its right partner completes; a new left slot drops any stale one.
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         left_hold_r <= {SAMPLE_W{1'b0}};
         left_held_r <= 1'b0;
         out_l_r     <= {SAMPLE_W{1'b0}};
         out_r_r     <= {SAMPLE_W{1'b0}};
         commit_r    <= 1'b0;
         valid_r     <= 1'b0;
         err_r       <= 1'b0;
      end else begin
         commit_r <= 1'b0;
         valid_r  <= commit_r;
         err_r    <= err_s;
         if (lr_edge_s && (lrck_s == LEFT_LVL)) begin
            left_held_r <= 1'b0;
         end else if (last_s && is_left_s) begin
            left_hold_r <= word_s;
            left_held_r <= 1'b1;
         end else if (last_s && left_held_r) begin
            out_l_r     <= left_hold_r;
            out_r_r     <= word_s;
            left_held_r <= 1'b0;
            commit_r    <= 1'b1;
         end
      end
   end

   assign oAUD_inL   = out_l_r;
   assign oAUD_inR   = out_r_r;
   assign oVALID     = valid_r;
   assign oFRAME_ERR = err_r;

`ifdef ADC_PEAK_METER_EN
   logic [SAMPLE_W-2:0] peak_l_r, peak_r_r, mag_l_s, mag_r_s;

   // |s| with the most negative code clamped to the largest positive magnitude.
   function automatic logic [SAMPLE_W-2:0] mag_sat(input logic [SAMPLE_W-1:0] s);
      logic [SAMPLE_W-1:0] a;
      a = s[SAMPLE_W-1] ? (~s + {{(SAMPLE_W-1){1'b0}}, 1'b1}) : s;
      return a[SAMPLE_W-1] ? {(SAMPLE_W-1){1'b1}} : a[SAMPLE_W-2:0];
   endfunction

   assign mag_l_s = mag_sat(out_l_r);
   assign mag_r_s = mag_sat(out_r_r);

   // Running peaks, sampled while the new pair is presented.
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         peak_l_r <= {(SAMPLE_W-1){1'b0}};
         peak_r_r <= {(SAMPLE_W-1){1'b0}};
      end else if (iPEAK_CLR) begin
         peak_l_r <= valid_r ? mag_l_s : {(SAMPLE_W-1){1'b0}};
         peak_r_r <= valid_r ? mag_r_s : {(SAMPLE_W-1){1'b0}};
      end else if (valid_r) begin
         if (mag_l_s > peak_l_r) peak_l_r <= mag_l_s;
         if (mag_r_s > peak_r_r) peak_r_r <= mag_r_s;
      end
   end

   assign oPEAK_L = peak_l_r;
   assign oPEAK_R = peak_r_r;
`endif

endmodule
